seq_detector_param: RTL and testbench

- Parametrised serial pattern-detector FSM; successor to the team's fixed two-input Mealy/Moore FSM.
- Hunts for a PAT_W-bit pattern in a qualified serial bit stream.
- Raises both a combinational Mealy match and a registered Moore match.
- Keeps a saturating match counter; supports overlapping or non-overlapping detection, selected by parameter.

---
 rtl/seq_detector_param.sv | 113 +++++++++++
 tb/tb_seq_detector_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with Mealy/Moore match and saturating counter
module seq_detector_param #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit              OVERLAP = 1'b1,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    input  logic             din_valid,
    output logic             mealy_match,
    output logic             moore_match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        HUNT = 2'b10,
        HIT  = 2'b11
    } state_t;

    localparam int               FILL_W  = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_t             state, state_nx;
    logic [PAT_W-2:0]   hist, hist_nx;
    logic [FILL_W-1:0]  fill, fill_nx, fill_inc;
    logic [CNT_W-1:0]   cnt_nx;
    logic               sat_nx;
    logic               accept, full, hit;
    logic [PAT_W-1:0]   candidate;

    assign accept      = en & din_valid & ~clr;
    assign candidate   = {hist, din};
    assign full        = (fill == FULL);
    assign hit         = accept & full & (candidate == PATTERN);
    assign fill_inc    = full ? fill : fill + FILL_W'(1);
    assign mealy_match = hit;
    assign moore_match = (state == HIT);
    assign state_o     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            fill      <= fill_nx;
            match_cnt <= cnt_nx;
            cnt_sat   <= sat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill;
        cnt_nx   = match_cnt;
        sat_nx   = cnt_sat;

        // Counter clear applies regardless of en; the search state follows en first.
        if (clr) begin
            cnt_nx = '0;
            sat_nx = 1'b0;
        end else if (hit && (match_cnt != CNT_MAX)) begin
            cnt_nx = match_cnt + CNT_W'(1);
            if (match_cnt == CNT_MAX - CNT_W'(1)) begin
                sat_nx = 1'b1;
            end
        end

        if (!en) begin
            state_nx = IDLE;
            hist_nx  = '0;
            fill_nx  = '0;
        end else if (clr) begin
            state_nx = FILL;
            hist_nx  = '0;
            fill_nx  = '0;
        end else if (hit) begin
            state_nx = HIT;
            if (OVERLAP) begin
                hist_nx = candidate[PAT_W-2:0];
                fill_nx = FULL;
            end else begin
                hist_nx = '0;
                fill_nx = '0;
            end
        end else if (accept) begin
            hist_nx  = candidate[PAT_W-2:0];
            fill_nx  = fill_inc;
            state_nx = (fill_inc == FULL) ? HUNT : FILL;
        end else begin
            case (state)
                IDLE:    state_nx = FILL;
                HIT:     state_nx = OVERLAP ? HUNT : FILL;
                default: state_nx = state;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed and random checks of seq_detector_param against a window model
module tb_seq_detector_param;

    localparam int         PAT_W = 4;
    localparam logic [3:0] PAT   = 4'b1101;

    logic       clk = 1'b0;
    logic       rst, en, clr, din, din_valid;
    logic       mealy0, moore0, sat0, mealy1, moore1, sat1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [1:0] st0, st1;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-instance model: index 0 = overlap/8-bit counter, 1 = non-overlap/2-bit counter
    int m_len[2];
    int m_val[2];
    int m_cnt[2];
    int m_state[2];
    bit m_sat[2];
    bit m_ovl[2] = '{1'b1, 1'b0};
    int m_max[2] = '{255, 3};

    seq_detector_param u_dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
        .mealy_match(mealy0), .moore_match(moore0), .match_cnt(cnt0), .cnt_sat(sat0), .state_o(st0)
    );

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
        .mealy_match(mealy1), .moore_match(moore1), .match_cnt(cnt1), .cnt_sat(sat1), .state_o(st1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_len[k] = 0; m_val[k] = 0; m_cnt[k] = 0; m_sat[k] = 1'b0; m_state[k] = 0;
        end
    endtask

    task automatic step(input bit e, input bit v, input bit d, input bit c);
        bit acc;
        bit hit[2];
        int nv[2];
        int nl[2];
        en = e; din_valid = v; din = d; clr = c;
        #3;
        acc = e && v && !c;
        for (int k = 0; k < 2; k++) begin
            nv[k]  = ((m_val[k] << 1) | int'(d)) & ((1 << PAT_W) - 1);
            nl[k]  = m_len[k] + 1;
            hit[k] = acc && (nl[k] == PAT_W) && (nv[k] == int'(PAT));
        end
        chk("mealy0", 32'(mealy0), 32'(hit[0]));
        chk("state0", 32'(st0), 32'(m_state[0]));
        chk("moore0", 32'(moore0), 32'(m_state[0] == 3));
        chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("sat0", 32'(sat0), 32'(m_sat[0]));
        chk("mealy1", 32'(mealy1), 32'(hit[1]));
        chk("state1", 32'(st1), 32'(m_state[1]));
        chk("moore1", 32'(moore1), 32'(m_state[1] == 3));
        chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
        chk("sat1", 32'(sat1), 32'(m_sat[1]));
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                m_cnt[k] = 0; m_sat[k] = 1'b0;
            end else if (hit[k] && m_cnt[k] != m_max[k]) begin
                m_cnt[k]++;
                if (m_cnt[k] == m_max[k]) m_sat[k] = 1'b1;
            end
            if (!e || c) begin
                m_len[k] = 0; m_val[k] = 0;
            end else if (hit[k]) begin
                m_len[k] = m_ovl[k] ? PAT_W - 1 : 0;
                m_val[k] = m_ovl[k] ? (nv[k] & ((1 << (PAT_W - 1)) - 1)) : 0;
            end else if (acc) begin
                m_len[k] = (nl[k] > PAT_W - 1) ? PAT_W - 1 : nl[k];
                m_val[k] = nv[k] & ((1 << (PAT_W - 1)) - 1);
            end
            m_state[k] = !e ? 0 : hit[k] ? 3 : (m_len[k] == PAT_W - 1) ? 2 : 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i], 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; din = 1'b0; din_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then basic match 1101
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(8'b1101, 4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_cnt0", 32'(cnt0), 32'd1);

        // Overlapping vs non-overlapping on 1101101
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send(8'b1101101, 7);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_cnt0", 32'(cnt0), 32'd2);
        chk("t2_cnt1", 32'(cnt1), 32'd1);

        // Gaps between valid bits with toggling idle data
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, 1'b1, PAT[i], 1'b0);
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        chk("t3_cnt0", 32'(cnt0), 32'd1);

        // Saturation of the 2-bit counter
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int m = 0; m < 4; m++) send(8'b11010, 5);
        chk("t4_cnt1", 32'(cnt1), 32'd3);
        chk("t4_sat1", 32'(sat1), 32'd1);
        chk("t4_cnt0", 32'(cnt0), 32'd4);

        // Clear drops the completing bit
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send(8'b110, 3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_state0", 32'(st0), 32'd1);
        send(8'b1101, 4);
        chk("t5_cnt0", 32'(cnt0), 32'd1);

        // Asynchronous reset mid-stream
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send(8'b110, 3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t6_state0", 32'(st0), 32'd0);
        chk("t6_cnt0", 32'(cnt0), 32'd0);
        chk("t6_moore0", 32'(moore0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_cnt0_after", 32'(cnt0), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
